// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, movement tick generator with speed-up, and direction filter for the Snake datapath.
module snake_game_ctrl #(
  parameter int CNT_W = 27,
  parameter int TICK_DIV = 25_000_000,
  parameter int SPEED_STEP = 1_000_000,
  parameter int MIN_DIV = 5_000_000,
  parameter logic [7:0] WIN_LENGTH = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Btn_Up,
  input  logic       Btn_Down,
  input  logic       Btn_Left,
  input  logic       Btn_Right,
  input  logic       Collision,
  input  logic [7:0] Length,
  output logic       q_I,
  output logic       q_Run,
  output logic       q_Win,
  output logic       q_Lose,
  output logic       Speed_Clk,
  output logic       SCEN,
  output logic [1:0] In_Dirn,
  output logic       Dp_Reset
);
  typedef enum logic [3:0] {S_I = 4'b1000, S_RUN = 4'b0100, S_WIN = 4'b0010, S_LOSE = 4'b0001} state_t;
  localparam logic [CNT_W-1:0] P0 = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(SPEED_STEP);
  localparam logic [CNT_W-1:0] PMIN = CNT_W'(MIN_DIV);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, period, period_dec;
  logic [1:0] com_dirn, cand;
  logic [7:0] len_d;
  logic go, any_btn;
  assign {q_I, q_Run, q_Win, q_Lose} = state;
  assign go = q_I && Start;
  assign Speed_Clk = q_Run && (cnt >= period - 1'b1);
  assign any_btn = Btn_Up | Btn_Down | Btn_Left | Btn_Right;
  assign cand = Btn_Up ? 2'b00 : Btn_Down ? 2'b01 : Btn_Left ? 2'b10 : 2'b11;
  // reverse of the committed direction shares bit[1] and flips bit[0]
  assign SCEN = q_Run && any_btn && !Speed_Clk && cand != In_Dirn
                && !(cand[1] == com_dirn[1] && cand[0] != com_dirn[0]);
  assign period_dec = (period >= PMIN + STEP) ? period - STEP : PMIN;
  always_comb begin
    state_nx = state;
    case (state)
      S_I:     state_nx = Start ? S_RUN : S_I;
      S_RUN:   state_nx = Collision ? S_LOSE : (Length >= WIN_LENGTH) ? S_WIN : S_RUN;
      S_WIN,
      S_LOSE:  state_nx = Ack ? S_I : state;
      default: state_nx = S_I;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_I;
      cnt      <= '0;
      period   <= P0;
      In_Dirn  <= '0;
      com_dirn <= '0;
      len_d    <= 8'd3;
      Dp_Reset <= 1'b0;
    end else begin
      state    <= state_nx;
      Dp_Reset <= go;
      if (go) begin
        cnt      <= '0;
        period   <= P0;
        In_Dirn  <= '0;
        com_dirn <= '0;
        len_d    <= 8'd3;
      end else if (q_Run) begin
        len_d <= Length;
        // counter waits out the datapath reset cycle so the first tick lands TICK_DIV cycles in
        cnt <= Speed_Clk ? '0 : Dp_Reset ? cnt : cnt + 1'b1;
        if (Length > len_d) period <= period_dec;
        if (SCEN) In_Dirn <= cand;
        if (Speed_Clk) com_dirn <= In_Dirn;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed checks of FSM, tick cadence, speed-up and direction filter.
module tb_snake_game_ctrl;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0;
  logic Btn_Up = 1'b0, Btn_Down = 1'b0, Btn_Left = 1'b0, Btn_Right = 1'b0;
  logic Collision = 1'b0;
  logic [7:0] Length = 8'd3;
  logic q_I, q_Run, q_Win, q_Lose, Speed_Clk, SCEN, Dp_Reset;
  logic [1:0] In_Dirn;
  int checks = 0, errors = 0, n;
  always #5 Clk = ~Clk;
  snake_game_ctrl #(.CNT_W(8), .TICK_DIV(8), .SPEED_STEP(2), .MIN_DIV(4), .WIN_LENGTH(8'd5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Left(Btn_Left), .Btn_Right(Btn_Right),
    .Collision(Collision), .Length(Length),
    .q_I(q_I), .q_Run(q_Run), .q_Win(q_Win), .q_Lose(q_Lose),
    .Speed_Clk(Speed_Clk), .SCEN(SCEN), .In_Dirn(In_Dirn), .Dp_Reset(Dp_Reset)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask
  task automatic gap(output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!Speed_Clk && k < 40);
  endtask
  task automatic wait_tick;
    int k = 0;
    while (!Speed_Clk && k < 40) begin
      cyc();
      k++;
    end
    chk("wait_tick", 32'(Speed_Clk), 1);
  endtask
  initial begin
    #12;
    chk("rst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    chk("rst_outs", {Speed_Clk, SCEN, In_Dirn, Dp_Reset}, 5'b0);
    cyc(); Reset = 1'b0; cyc();
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("start_run", {q_I, q_Run, q_Win, q_Lose}, 4'b0100);
    chk("dp_reset_hi", 32'(Dp_Reset), 1);
    cyc();
    chk("dp_reset_lo", 32'(Dp_Reset), 0);
    gap(n); chk("first_tick_after_r1", n, 7);
    gap(n); chk("tick_period8", n, 8);
    cyc();
    Btn_Down = 1'b1; #1; chk("down_rev_scen", 32'(SCEN), 0);
    cyc(); Btn_Down = 1'b0; chk("down_rev_dirn", 32'(In_Dirn), 0);
    Btn_Left = 1'b1; #1; chk("left_scen", 32'(SCEN), 1);
    cyc(); Btn_Left = 1'b0; chk("left_dirn", 32'(In_Dirn), 2);
    Btn_Right = 1'b1; #1; chk("right_scen", 32'(SCEN), 1);
    cyc(); Btn_Right = 1'b0; chk("right_dirn", 32'(In_Dirn), 3);
    wait_tick();
    Btn_Up = 1'b1; #1; chk("tick_drop_scen", 32'(SCEN), 0);
    cyc(); Btn_Up = 1'b0; chk("tick_drop_dirn", 32'(In_Dirn), 3);
    Btn_Left = 1'b1; #1; chk("left_rev_scen", 32'(SCEN), 0);
    cyc(); Btn_Left = 1'b0; chk("left_rev_dirn", 32'(In_Dirn), 3);
    Btn_Up = 1'b1; Btn_Right = 1'b1; #1; chk("up_prio_scen", 32'(SCEN), 1);
    cyc(); Btn_Up = 1'b0; Btn_Right = 1'b0; chk("up_prio_dirn", 32'(In_Dirn), 0);
    wait_tick();
    Length = 8'd4;
    gap(n); chk("period6_a", n, 6);
    gap(n); chk("period6_b", n, 6);
    Length = 8'd3; cyc(); Length = 8'd4;
    gap(n); chk("period4_rest", n, 3);
    Length = 8'd3; cyc(); Length = 8'd4;
    gap(n); chk("period_floor_rest", n, 3);
    cyc(); Length = 8'd5; cyc();
    chk("win_state", {q_I, q_Run, q_Win, q_Lose}, 4'b0010);
    chk("win_no_tick", {Speed_Clk, SCEN}, 2'b00);
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("win_ignores_start", {q_I, q_Run, q_Win, q_Lose}, 4'b0010);
    Ack = 1'b1; cyc(); Ack = 1'b0;
    chk("win_ack", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    Length = 8'd3; Start = 1'b1; cyc(); Start = 1'b0; cyc();
    Btn_Left = 1'b1; cyc(); Btn_Left = 1'b0;
    chk("run2_left", 32'(In_Dirn), 2);
    Collision = 1'b1; Length = 8'd5; cyc();
    chk("lose_prio", {q_I, q_Run, q_Win, q_Lose}, 4'b0001);
    Collision = 1'b0; Length = 8'd3; Ack = 1'b1; cyc(); Ack = 1'b0;
    chk("lose_ack", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    chk("idle_hold_dirn", 32'(In_Dirn), 2);
    Start = 1'b1; cyc(); Start = 1'b0;
    chk("restart_dirn", 32'(In_Dirn), 0);
    chk("restart_dp_reset", 32'(Dp_Reset), 1);
    gap(n); chk("restart_period8", n, 8);
    cyc();
    Btn_Right = 1'b1; cyc(); Btn_Right = 1'b0;
    chk("pre_reset_dirn", 32'(In_Dirn), 3);
    cyc(); cyc(); #2;
    Reset = 1'b1; #1;
    chk("async_rst_state", {q_I, q_Run, q_Win, q_Lose}, 4'b1000);
    chk("async_rst_outs", {Speed_Clk, SCEN, In_Dirn, Dp_Reset}, 5'b0);
    cyc(); Reset = 1'b0; cyc();
    Start = 1'b1; cyc(); Start = 1'b0;
    gap(n); chk("post_rst_period8", n, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Control unit for the Snake datapath. It runs the game state machine (Initial / Run / Win / Lose), generates the movement tick that advances the snake, and filters the four direction buttons into the direction code and strobe the length/position datapath consumes. It sits between the debounced board inputs and the datapath, whose Collision and Length outputs feed back into this block.

## Interface
Parameters:
- CNT_W, 27: width of tick counter and period register.
- TICK_DIV, 25_000_000: initial tick period in Clk cycles. 100 MHz gives 4 moves/s.
- SPEED_STEP, 1_000_000: period reduction per apple eaten.
- MIN_DIV, 5_000_000: floor for the tick period.
- WIN_LENGTH, 8'd30: snake length that wins the game.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; all registers go to reset values immediately.
- Start  in  1  single-cycle debounced pulse; starts a game from Initial.
- Ack  in  1  single-cycle pulse; returns Win/Lose to Initial.
- Btn_Up, Btn_Down, Btn_Left, Btn_Right  in  1 each  single-cycle debounced pulses.
- Collision  in  1  datapath collision flag (level).
- Length  in  8  datapath snake length.
- q_I, q_Run, q_Win, q_Lose  out  1 each  one-hot state outputs.
- Speed_Clk  out  1  one-cycle movement tick.
- SCEN  out  1  one-cycle strobe, high in the cycle In_Dirn takes a new value.
- In_Dirn  out  2  direction: 00 up, 01 down, 10 left, 11 right.
- Dp_Reset  out  1  one-cycle synchronous reset pulse to the datapath on game start.

## Operation
- The state register is one-hot {q_I, q_Run, q_Win, q_Lose}. Reset value is q_I=1, all others 0.
- Transitions:
  - I -> Run on Start.
  - Run -> Lose when Collision=1.
  - Run -> Win when Length >= WIN_LENGTH and Collision=0. If both hold in the same cycle, Lose has priority.
  - Win/Lose -> I on Ack.
  - Start is ignored outside I. Ack is ignored outside Win/Lose.
- Dp_Reset is registered and high for exactly the one cycle after the I->Run edge, i.e. the first Run cycle.
- On entering Run:
  - Tick counter = 0, Period = TICK_DIV.
  - In_Dirn = 00, Committed_Dirn = 00.
  - Length_d = 3.
- Tick generation, Run only:
  - Speed_Clk = q_Run && (counter >= Period-1), decoded from registers.
  - The counter resets to 0 on a Speed_Clk cycle and otherwise increments.
  - Outside Run the counter holds 0 and Speed_Clk=0.
- Speed-up, Run only:
  - Length_d registers Length every cycle.
  - When Length > Length_d, Period <= max(Period - SPEED_STEP, MIN_DIV). Subtraction saturates and never underflows.
  - Because the comparison is >=, a shortened Period that falls below the current count fires Speed_Clk on the next cycle.
- Direction filter, Run only:
  - Button priority: Up > Down > Left > Right. Only the highest-priority asserted button is considered.
  - A candidate D is accepted when all three hold:
    - D != In_Dirn;
    - D is not the reverse of Committed_Dirn (reverse means same bit[1], different bit[0]);
    - Speed_Clk=0 in that cycle.
  - Buttons arriving in a Speed_Clk cycle are dropped, not queued.
  - On accept: In_Dirn <= D and SCEN=1 in the same cycle as the registered update (SCEN is combinational from the accept condition).
  - On each Speed_Clk: Committed_Dirn <= In_Dirn, which is the direction the datapath moves with on that tick.
  - Consequence: two turns within one tick can never produce a 180° reversal.
- Win/Lose/I: In_Dirn, Period and Committed_Dirn hold. SCEN=0, Speed_Clk=0.

## Timing
- Reset values: q_I=1, q_Run=0, q_Win=0, q_Lose=0, Speed_Clk=0, SCEN=0, In_Dirn=00, Dp_Reset=0, counter=0, Period=TICK_DIV.
- Start at cycle t gives q_Run=1 and Dp_Reset=1 at t+1.
- The first Speed_Clk comes in the cycle where counter = TICK_DIV-1, which is TICK_DIV cycles after the first Run cycle. Speed_Clk then repeats every Period cycles.
- Collision or win condition sampled at cycle t gives the state change at t+1. Speed_Clk and SCEN are 0 from t+1.
- Button pulse at t (accepted) gives SCEN=1 at t and In_Dirn updated at t+1.
- Length increase seen at t (Length vs Length_d) gives the new Period used from t+1.
- Reset asserted mid-game returns every output to its reset value without waiting for a clock edge.

## Test plan
Use TICK_DIV=8, SPEED_STEP=2, MIN_DIV=4, WIN_LENGTH=5.
1. Reset, then Start pulse -> q_Run=1 and Dp_Reset=1 for one cycle; Speed_Clk pulses every 8 cycles, first pulse 8 cycles after the first Run cycle.
2. In Run with Committed_Dirn=00, pulse Btn_Down -> no SCEN, In_Dirn stays 00; pulse Btn_Left -> SCEN=1, In_Dirn=10; then Btn_Right before the next tick -> accepted (Committed still 00), In_Dirn=11.
3. After a tick commits 11, pulse Btn_Left -> rejected; pulse Btn_Up together with Btn_Right -> Up wins, In_Dirn=00. Any button in a Speed_Clk cycle -> dropped.
4. Length steps 3->4->5 while Collision=0 -> Period goes 8->6 then 6->4, and Length=5 moves the state to q_Win next cycle. Ack -> q_I.
5. Collision=1 in the same cycle as Length=5 -> q_Lose. Ack -> q_I. A new Start gives Period=8 and In_Dirn=00.
6. Assert Reset mid-Run between ticks -> all outputs immediately at reset values. Deassert, then Start -> normal tick cadence from 0.
